fp_decode: RTL and testbench
============================

FP_DECODE -- requirements
Module: fp_decode

Interface
REQ-001 The block SHALL have parameter NEG_ZERO_AS_MIN, default 0; when 1, float code 0x80 decodes to -2048 instead of 0.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1 bit: in_float is valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept a float code.
REQ-006 The block SHALL have port in_float, input, 8 bits: [7] sign S, [6:4] exponent E, [3:0] significand F.
REQ-007 The block SHALL have port out_valid, output, 1 bit: out_linear holds a decoded result.
REQ-008 The block SHALL have port out_ready, input, 1 bit: the sink accepts out_linear.
REQ-009 The block SHALL have port out_linear, output, 12 bits: two's-complement linear value.
REQ-010 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-011 The decoded value SHALL be (F << E), an 11-bit unsigned magnitude, negated when S=1 (12-bit two's complement; range -1920..+1920).
REQ-012 Code 0x80 (S=1, E=0, F=0) SHALL decode to 0x000 when NEG_ZERO_AS_MIN=0 and to 0x800 when NEG_ZERO_AS_MIN=1.
REQ-013 The FSM SHALL have states IDLE, SHIFT, NEG and HOLD; in_ready SHALL equal (state==IDLE).
REQ-014 Accept: in IDLE with in_valid=1, the block SHALL capture S, load cnt=E (3 bits) and mag={7'b0,F} (11 bits), and go to SHIFT.
REQ-015 In IDLE with in_valid=0, the block SHALL stay in IDLE.
REQ-016 In SHIFT with cnt!=0, the block SHALL set mag <= mag<<1 and cnt <= cnt-1, and stay in SHIFT.
REQ-017 In SHIFT with cnt==0, the block SHALL go to NEG, so SHIFT lasts exactly E+1 cycles.
REQ-018 In NEG, the block SHALL register out_linear (sign applied per REQ-011/012), set out_valid=1 and go to HOLD.
REQ-019 Latency: if accepted at edge k, out_valid SHALL first be high after edge k+E+2 (2 to 9 cycles).
REQ-020 In HOLD, out_valid SHALL stay 1 and out_linear SHALL stay constant until out_valid&&out_ready is sampled high.
REQ-021 On that handshake edge, the block SHALL clear out_valid and return to IDLE; out_linear SHALL keep its last value.
REQ-022 in_valid is ignored outside IDLE; an input arriving then SHALL NOT be captured and stays pending at the source.
REQ-023 Throughput SHALL be at most one conversion per E+4 cycles, with zero backpressure.
REQ-024 A shift SHALL never overflow: the maximum magnitude 15<<7 = 1920 fits in 11 bits, so no saturation logic is needed.
REQ-025 out_ready high outside HOLD SHALL have no effect.

Reset
REQ-026 While rst_n=0 at a rising edge, the block SHALL set: state=IDLE, out_valid=0, out_linear=0x000, cnt=0, mag=0, captured sign=0.
REQ-027 Reset SHALL override every state, including mid-SHIFT and HOLD; an aborted conversion SHALL NOT be emitted afterwards.
REQ-028 After the first edge with rst_n=1, in_ready=1, busy=0 and out_valid=0.

Verification
REQ-029 Zero code: in_float=0x00, out_ready=1 -> out_valid after 2 cycles, out_linear=0x000; back in IDLE next cycle.
REQ-030 Maximum positive: in_float=0x7F (S0, E7, F15) -> out_linear=0x780 (+1920), out_valid exactly 9 cycles after accept.
REQ-031 Negative mid-range: in_float=0xB5 (S1, E3, F5) -> out_linear=0xFD8 (-40), latency 5.
REQ-032 Backpressure: 0x2A decoded (+40 = 0x028) with out_ready=0 for 10 cycles, and a second in_valid held meanwhile -> out_linear stays 0x028, in_ready=0, second code not accepted; after out_ready=1 handshake, second code accepted the next IDLE cycle.
REQ-033 Reset mid-operation: accept 0x7F, drop rst_n for one edge during SHIFT -> next cycle state IDLE, out_valid=0, out_linear=0x000, and no output appears within 12 cycles.
REQ-034 Parameter case: NEG_ZERO_AS_MIN=1, in_float=0x80 -> out_linear=0x800; with default 0 -> 0x000.

Source files
------------

// File: rtl/fp_decode.sv
// ---------------------------------------------------------------------------
// fp_decode
//   Converts an 8-bit mini-float code into a 12-bit two's-complement linear
//   value. The significand is shifted left one bit per cycle, so a conversion
//   takes E+2 cycles from accept to out_valid. The result is held until the
//   sink takes it.
//
//   Code layout: [7] sign S, [6:4] exponent E, [3:0] significand F.
//   Value: (F << E) as an 11-bit magnitude, negated when S=1.
//   Code 0x80 decodes to 0x800 when NEG_ZERO_AS_MIN=1, otherwise to 0x000.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
//   both high. in_ready is high only in IDLE. Once out_valid rises, it and
//   out_linear stay stable until the edge where out_ready is sampled high.
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   synchronous active-low reset
//   in_valid   in   in_float holds a code
//   in_ready   out  block can accept a code (state == IDLE)
//   in_float   in   8-bit float code
//   out_valid  out  out_linear holds a decoded result
//   out_ready  in   sink accepts out_linear
//   out_linear out  12-bit two's-complement result
//   busy       out  high in every state except IDLE
//   dbg_state  out  current FSM state (0 IDLE, 1 SHIFT, 2 NEG, 3 HOLD)
// ---------------------------------------------------------------------------
module fp_decode #(
    parameter bit NEG_ZERO_AS_MIN = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_float,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [11:0] out_linear,
    output logic        busy,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        NEG   = 2'd2,
        HOLD  = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [10:0] mag_q, mag_d;
    logic        sign_q, sign_d;
    logic        is_min_q, is_min_d;   // captured code was exactly 0x80
    logic        out_valid_q, out_valid_d;
    logic [11:0] out_linear_q, out_linear_d;

    logic [11:0] mag_ext;
    logic [11:0] signed_val;

    // The magnitude never exceeds 1920, so the 12-bit negation cannot wrap.
    always_comb begin
        mag_ext = {1'b0, mag_q};
        if (NEG_ZERO_AS_MIN && is_min_q) begin
            signed_val = 12'h800;
        end else if (sign_q) begin
            signed_val = ~mag_ext + 12'd1;
        end else begin
            signed_val = mag_ext;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        mag_d        = mag_q;
        sign_d       = sign_q;
        is_min_d     = is_min_q;
        out_valid_d  = out_valid_q;
        out_linear_d = out_linear_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d   = in_float[7];
                    cnt_d    = in_float[6:4];
                    mag_d    = {7'b0, in_float[3:0]};
                    is_min_d = (in_float == 8'h80);
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                // One extra cycle with cnt==0 makes SHIFT last E+1 cycles.
                if (cnt_q != 3'd0) begin
                    mag_d = mag_q << 1;
                    cnt_d = cnt_q - 3'd1;
                end else begin
                    state_d = NEG;
                end
            end
            NEG: begin
                out_linear_d = signed_val;
                out_valid_d  = 1'b1;
                state_d      = HOLD;
            end
            HOLD: begin
                // out_linear keeps its value after the handshake.
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= 3'd0;
            mag_q        <= 11'd0;
            sign_q       <= 1'b0;
            is_min_q     <= 1'b0;
            out_valid_q  <= 1'b0;
            out_linear_q <= 12'h000;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mag_q        <= mag_d;
            sign_q       <= sign_d;
            is_min_q     <= is_min_d;
            out_valid_q  <= out_valid_d;
            out_linear_q <= out_linear_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign out_valid  = out_valid_q;
    assign out_linear = out_linear_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_fp_decode.sv
module tb_fp_decode;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_float;
  logic        out_ready;

  logic        in_ready, out_valid, busy;
  logic [11:0] out_linear;
  logic [1:0]  dbg_state;

  logic        in_ready_nz, out_valid_nz, busy_nz;
  logic [11:0] out_linear_nz;
  logic [1:0]  dbg_state_nz;

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  fp_decode dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_float(in_float), .out_valid(out_valid), .out_ready(out_ready),
    .out_linear(out_linear), .busy(busy), .dbg_state(dbg_state)
  );

  fp_decode #(.NEG_ZERO_AS_MIN(1'b1)) dut_nz (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_nz),
    .in_float(in_float), .out_valid(out_valid_nz), .out_ready(out_ready),
    .out_linear(out_linear_nz), .busy(busy_nz), .dbg_state(dbg_state_nz)
  );

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [11:0] ref_decode(input logic [7:0] code, input bit nz);
    int e, m, v;
    e = int'(code[6:4]);
    m = int'(code[3:0]) * (1 << e);
    if (nz && code == 8'h80) v = -2048;
    else if (code[7]) v = -m;
    else v = m;
    return v[11:0];
  endfunction

  // ---------------- scoreboard ----------------
  logic [11:0] exp_q[$];
  logic [11:0] exp_nz_q[$];
  bit  in_flight = 0;
  bit  prev_ov = 0;
  bit  rst_chk = 0;
  int  acc_cyc = 0;
  int  exp_lat = 0;
  int  n_done = 0;

  always @(negedge clk) begin
    if (rst_chk) begin
      check_eq("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check_eq("rst_out_linear", {20'b0, out_linear}, 32'h000);
      check_eq("rst_out_linear_nz", {20'b0, out_linear_nz}, 32'h000);
      check_eq("rst_in_ready", {31'b0, in_ready}, 32'd1);
      check_eq("rst_busy", {31'b0, busy}, 32'd0);
      rst_chk = 0;
    end
    if (!rst_n) begin
      exp_q.delete();
      exp_nz_q.delete();
      in_flight = 0;
      prev_ov = 0;
      rst_chk = 1;
    end else begin
      check_eq("in_ready", {31'b0, in_ready}, {31'b0, !in_flight});
      check_eq("busy", {31'b0, busy}, {31'b0, in_flight});
      check_eq("in_ready_nz", {31'b0, in_ready_nz}, {31'b0, !in_flight});
      if (!in_flight) begin
        check_eq("spurious_out_valid", {31'b0, out_valid}, 32'd0);
      end else if (out_valid && exp_q.size() > 0) begin
        if (!prev_ov) check_eq("latency", cyc - acc_cyc, exp_lat);
        check_eq("out_linear", {20'b0, out_linear}, {20'b0, exp_q[0]});
        check_eq("out_linear_nz", {20'b0, out_linear_nz}, {20'b0, exp_nz_q[0]});
        check_eq("out_valid_nz", {31'b0, out_valid_nz}, 32'd1);
        if (out_ready) begin
          void'(exp_q.pop_front());
          void'(exp_nz_q.pop_front());
          in_flight = 0;
          n_done++;
        end
      end else if (cyc - acc_cyc > 10) begin
        check_eq("out_timeout", 32'd0, 32'd1);
        exp_q.delete();
        exp_nz_q.delete();
        in_flight = 0;
      end
      prev_ov = out_valid;
      if (in_valid && in_ready && exp_q.size() == 0) begin
        exp_q.push_back(ref_decode(in_float, 1'b0));
        exp_nz_q.push_back(ref_decode(in_float, 1'b1));
        acc_cyc = cyc + 1;
        exp_lat = int'(in_float[6:4]) + 2;
        in_flight = 1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [7:0] code);
    bit ok;
    ok = 0;
    in_valid = 1'b1;
    in_float = code;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check_eq("accept_timeout", 32'd0, 32'd1);
    #1 in_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] dir_codes[6];

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_float = 8'h00;
    out_ready = 1'b1;
    dir_codes = '{8'h00, 8'h7F, 8'hB5, 8'h80, 8'h90, 8'hFF};
    idle_cycles(3);
    rst_n = 1'b1;
    idle_cycles(1);

    // directed codes, sink always ready
    foreach (dir_codes[i]) send(dir_codes[i]);
    idle_cycles(12);

    // backpressure with a second code held pending
    out_ready = 1'b0;
    send(8'h2A);
    in_valid = 1'b1;
    in_float = 8'hB5;
    idle_cycles(16);
    out_ready = 1'b1;
    send(8'hB5);
    idle_cycles(12);

    // reset during SHIFT
    send(8'h7F);
    idle_cycles(3);
    rst_n = 1'b0;
    idle_cycles(1);
    rst_n = 1'b1;
    idle_cycles(12);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk);
      #1;
      in_valid = ($urandom_range(0, 2) != 0);
      in_float = ($urandom_range(0, 15) == 0) ? 8'h80 : 8'($urandom());
      out_ready = ($urandom_range(0, 3) != 0);
      rst_n = ($urandom_range(0, 299) != 0);
    end
    rst_n = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    idle_cycles(20);

    check_eq("enough_done", {31'b0, n_done >= 50}, 32'd1);
    check_eq("drained", {31'b0, in_flight}, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
